// File: rtl/aes_sched_pkg.sv
// Shared constants for the multi-requester AES scheduler: wrapper command
// addresses and the sequencer state encoding.
package aes_sched_pkg;

    localparam logic [15:0] AES_WRITE_KEY_HIGH_ADDR   = 16'h0010;
    localparam logic [15:0] AES_WRITE_KEY_LOW_ADDR    = 16'h0020;
    localparam logic [15:0] AES_WRITE_PLAIN_HIGH_ADDR = 16'h0030;
    localparam logic [15:0] AES_WRITE_PLAIN_LOW_ADDR  = 16'h0040;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_KEY_HI = 3'd1;
    localparam logic [2:0] ST_KEY_LO = 3'd2;
    localparam logic [2:0] ST_PT_HI  = 3'd3;
    localparam logic [2:0] ST_PT_LO  = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        KEY_HI = ST_KEY_HI,
        KEY_LO = ST_KEY_LO,
        PT_HI  = ST_PT_HI,
        PT_LO  = ST_PT_LO
    } sched_state_t;

endpackage

// File: rtl/aes_sched_id_fifo.sv
// Synchronous FIFO holding the requester ID of every job issued to the AES
// wrapper, so ciphertexts can be routed back in issue order.
module aes_sched_id_fifo
    import aes_sched_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap explicitly so non-power-of-two depths also work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/aes_multi_req_scheduler.sv
// Round-robin sharing of one buffered AES wrapper between NUM_REQ requesters.
// Optional key cache (skips repeated key writes): define AES_SCHED_KEY_CACHE_EN.
module aes_multi_req_scheduler
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ID_FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_val,
    output logic [NUM_REQ-1:0]     req_rdy,
    input  logic [NUM_REQ*128-1:0] req_key,
    input  logic [NUM_REQ*128-1:0] req_plain,
    output logic [NUM_REQ-1:0]     rsp_val,
    input  logic [NUM_REQ-1:0]     rsp_rdy,
    output logic [127:0]           rsp_data,
    output logic                   config_hsk,
    output logic [15:0]            config_addr,
    output logic [31:0]            config_data_hi,
    output logic [31:0]            config_data_lo,
    output logic                   config_load,
    input  logic                   aes_ready,
    input  logic                   buffer_val,
    input  logic [127:0]           buffer_data,
    output logic                   buffer_pop
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ID_FIFO_DEPTH + 1);

    sched_state_t      state, next_state;
    logic [ID_W-1:0]   rr_ptr, grant_id, scan_idx, job_id, fifo_head;
    logic              grant_found, grant, key_hit, fifo_has_room;
    logic [127:0]      sel_key, sel_plain, job_key, job_plain;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!grant_found && req_val[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    assign fifo_has_room = (fifo_count < CNT_W'(ID_FIFO_DEPTH)) && !fifo_full;
    assign grant         = (state == IDLE) && grant_found && fifo_has_room;
    assign sel_key       = req_key[int'(grant_id)*128 +: 128];
    assign sel_plain     = req_plain[int'(grant_id)*128 +: 128];

`ifdef AES_SCHED_KEY_CACHE_EN
    logic [127:0] last_key;
    logic         key_valid;

    assign key_hit = key_valid && (sel_key == last_key);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
        end else if (state == KEY_LO) begin
            last_key  <= job_key;
            key_valid <= 1'b1;
        end
    end
`else
    assign key_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (grant) next_state = key_hit ? PT_HI : KEY_HI;
            KEY_HI:  next_state = KEY_LO;
            KEY_LO:  next_state = PT_HI;
            PT_HI:   next_state = PT_LO;
            PT_LO:   if (aes_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr    <= ID_W'((int'(grant_id) + 1) % NUM_REQ);
            job_key   <= sel_key;
            job_plain <= sel_plain;
            job_id    <= grant_id;
        end
    end

    // Every output is forced low while reset is asserted.
    always_comb begin
        req_rdy        = '0;
        config_hsk     = 1'b0;
        config_addr    = '0;
        config_data_hi = '0;
        config_data_lo = '0;
        if (rst_n) begin
            unique case (state)
                IDLE: if (grant) req_rdy[grant_id] = 1'b1;
                KEY_HI: begin
                    config_hsk     = 1'b1;
                    config_addr    = AES_WRITE_KEY_HIGH_ADDR;
                    config_data_hi = job_key[127:96];
                    config_data_lo = job_key[95:64];
                end
                KEY_LO: begin
                    config_hsk     = 1'b1;
                    config_addr    = AES_WRITE_KEY_LOW_ADDR;
                    config_data_hi = job_key[63:32];
                    config_data_lo = job_key[31:0];
                end
                PT_HI: begin
                    config_hsk     = 1'b1;
                    config_addr    = AES_WRITE_PLAIN_HIGH_ADDR;
                    config_data_hi = job_plain[127:96];
                    config_data_lo = job_plain[95:64];
                end
                PT_LO: if (aes_ready) begin
                    config_hsk     = 1'b1;
                    config_addr    = AES_WRITE_PLAIN_LOW_ADDR;
                    config_data_hi = job_plain[63:32];
                    config_data_lo = job_plain[31:0];
                end
                default: ;
            endcase
        end
    end

    assign fifo_push = (state == PT_LO) && aes_ready;

    always_comb begin
        rsp_val = '0;
        if (rst_n && buffer_val && !fifo_empty) rsp_val[fifo_head] = 1'b1;
    end

    assign fifo_pop    = rst_n && buffer_val && !fifo_empty && rsp_rdy[fifo_head];
    assign buffer_pop  = fifo_pop;
    assign rsp_data    = rst_n ? buffer_data : '0;
    assign config_load = 1'b0;

    aes_sched_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (ID_FIFO_DEPTH)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (job_id),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_aes_multi_req_scheduler.sv
// Bench for aes_multi_req_scheduler: transaction-level model of arbitration,
// config write sequencing and in-order response routing, plus a wrapper model.
module tb_aes_multi_req_scheduler;

    localparam int N     = 4;
    localparam int DEPTH = 16;
    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_val = '0, req_rdy, rsp_val, rsp_rdy = '1;
    logic [N*128-1:0] req_key = '0, req_plain = '0;
    logic [127:0]     rsp_data, buffer_data;
    logic             config_hsk, config_load, aes_ready = 1'b1, buffer_val, buffer_pop;
    logic [15:0]      config_addr;
    logic [31:0]      config_data_hi, config_data_lo;

    aes_multi_req_scheduler #(.NUM_REQ(N), .ID_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_rdy(req_rdy),
        .req_key(req_key), .req_plain(req_plain), .rsp_val(rsp_val), .rsp_rdy(rsp_rdy),
        .rsp_data(rsp_data), .config_hsk(config_hsk), .config_addr(config_addr),
        .config_data_hi(config_data_hi), .config_data_lo(config_data_lo),
        .config_load(config_load), .aes_ready(aes_ready), .buffer_val(buffer_val),
        .buffer_data(buffer_data), .buffer_pop(buffer_pop)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    longint cyc  = 0;

    typedef struct { logic [15:0] addr; logic [31:0] hi; logic [31:0] lo; } wr_t;
    typedef struct { logic [15:0] addr; logic [31:0] hi; logic [31:0] lo; longint c; } wlog_t;
    typedef struct { int id; logic [127:0] data; } rlog_t;

    wlog_t  write_log[$];
    rlog_t  rsp_log[$];
    int     grant_log[$];
    longint grant_cyc[$];

    // Stand-in cipher: the real AES result for the reference vector, a fixed scramble otherwise.
    function automatic logic [127:0] fakeAes(input logic [127:0] k, input logic [127:0] p);
        if (k == KEY1 && p == PT1) return CT1;
        return {k[63:0], k[127:64]} ^ p ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Wrapper model: collects config writes, queues ciphertexts, head visible after a short latency.
    logic [127:0] w_key = '0, w_plain = '0;
    logic [127:0] wq[$];
    longint       wt[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            wq.delete();
            wt.delete();
            buffer_val  <= 1'b0;
            buffer_data <= '0;
        end else begin
            if (buffer_pop && wq.size() > 0) begin
                void'(wq.pop_front());
                void'(wt.pop_front());
            end
            if (config_hsk) begin
                case (config_addr)
                    16'h0010: w_key[127:64]   <= {config_data_hi, config_data_lo};
                    16'h0020: w_key[63:0]     <= {config_data_hi, config_data_lo};
                    16'h0030: w_plain[127:64] <= {config_data_hi, config_data_lo};
                    16'h0040: begin
                        wq.push_back(fakeAes(w_key, {w_plain[127:64], config_data_hi, config_data_lo}));
                        wt.push_back(cyc + 3);
                    end
                    default: ;
                endcase
            end
            buffer_val  <= (wq.size() > 0) && (wt[0] <= cyc);
            buffer_data <= (wq.size() > 0) ? wq[0] : '0;
        end
    end

    // Scheduler model, evaluated mid-cycle once inputs and outputs are settled.
    int           m_rr = 0;
    int           m_ids[$];
    logic [127:0] m_cts[$];
    bit           m_active = 0;
    wr_t          m_wr[$];
    int           m_job_id;
    logic [127:0] m_job_key, m_job_plain, m_last_key;
    bit           m_key_valid = 0;
    int           grant_seen = -1;

    always @(negedge clk) begin
        logic [N-1:0] want_rdy, want_val;
        logic         want_hsk, want_pop, do_push, skip;
        int           g;
        wr_t          w;
        if (!rst_n) begin
            checkOutput("reset_outputs",
                {req_rdy, rsp_val, config_hsk, config_load, buffer_pop, config_addr, config_data_hi, config_data_lo}, '0);
            checkOutput("reset_rsp_data", rsp_data, '0);
            m_rr = 0; m_ids.delete(); m_cts.delete(); m_wr.delete();
            m_active = 0; m_key_valid = 0; grant_seen = -1;
        end else begin
            want_rdy = '0; g = -1; grant_seen = -1; do_push = 0;
            if (!m_active && m_ids.size() < DEPTH) begin
                for (int i = 0; i < N; i++) begin
                    if (g < 0 && req_val[(m_rr + i) % N]) g = (m_rr + i) % N;
                end
                if (g >= 0) want_rdy[g] = 1'b1;
            end
            checkOutput("req_rdy", req_rdy, want_rdy);

            want_hsk = m_active && (m_wr[0].addr != 16'h0040 || aes_ready);
            checkOutput("config_hsk", config_hsk, want_hsk);
            checkOutput("config_load", config_load, 1'b0);
            if (want_hsk) begin
                w = m_wr.pop_front();
                checkOutput("config_write", {config_addr, config_data_hi, config_data_lo}, {w.addr, w.hi, w.lo});
                write_log.push_back('{config_addr, config_data_hi, config_data_lo, cyc});
                if (w.addr == 16'h0020) begin m_last_key = m_job_key; m_key_valid = 1; end
                if (w.addr == 16'h0040) do_push = 1;
            end

            want_val = '0;
            if (buffer_val && m_ids.size() > 0) want_val[m_ids[0]] = 1'b1;
            checkOutput("rsp_val", rsp_val, want_val);
            want_pop = (want_val != '0) && rsp_rdy[m_ids[0]];
            if (want_val != '0) begin
                checkOutput("rsp_data", rsp_data, buffer_data);
                checkOutput("rsp_cipher", rsp_data, m_cts[0]);
            end
            checkOutput("buffer_pop", buffer_pop, want_pop);
            if (want_pop) begin
                rsp_log.push_back('{m_ids[0], rsp_data});
                void'(m_ids.pop_front());
                void'(m_cts.pop_front());
            end

            if (do_push) begin
                m_ids.push_back(m_job_id);
                m_cts.push_back(fakeAes(m_job_key, m_job_plain));
                m_active = 0;
            end
            if (g >= 0) begin
                m_job_id = g; m_job_key = req_key[g*128 +: 128]; m_job_plain = req_plain[g*128 +: 128];
                skip = 0;
`ifdef AES_SCHED_KEY_CACHE_EN
                skip = m_key_valid && (m_job_key == m_last_key);
`endif
                if (!skip) begin
                    m_wr.push_back('{16'h0010, m_job_key[127:96], m_job_key[95:64]});
                    m_wr.push_back('{16'h0020, m_job_key[63:32], m_job_key[31:0]});
                end
                m_wr.push_back('{16'h0030, m_job_plain[127:96], m_job_plain[95:64]});
                m_wr.push_back('{16'h0040, m_job_plain[63:32], m_job_plain[31:0]});
                m_active = 1; m_rr = (g + 1) % N; grant_seen = g;
                grant_log.push_back(g); grant_cyc.push_back(cyc);
            end
        end
    end

    // Requester behaviour: each holds its current job until granted, then moves on.
    logic [127:0] cur_key[N], cur_plain[N];
    int           jobs_left[N];
    bit           fixed_key = 0;

    task automatic driveReq(input int r);
        req_key[r*128 +: 128]   = cur_key[r];
        req_plain[r*128 +: 128] = cur_plain[r];
        req_val[r]              = (jobs_left[r] > 0);
    endtask

    task automatic loadJobs(input int r, input int n, input logic [127:0] k, input logic [127:0] p);
        jobs_left[r] = n; cur_key[r] = k; cur_plain[r] = p;
        driveReq(r);
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk); #1;
            if (grant_seen >= 0 && jobs_left[grant_seen] > 0) begin
                jobs_left[grant_seen]--;
                if (!fixed_key) cur_key[grant_seen] = cur_key[grant_seen] + 128'h0101;
                cur_plain[grant_seen] = cur_plain[grant_seen] + 128'h1_0000_0003;
                driveReq(grant_seen);
            end
        end
    endtask

    function automatic bit busy();
        int s = 0;
        for (int r = 0; r < N; r++) s += jobs_left[r];
        return (s > 0) || m_active || (m_ids.size() > 0);
    endfunction

    task automatic waitDrain(input int budget);
        int k = 0;
        while (busy() && k < budget) begin applyStimulus(1); k++; end
        if (k >= budget) checkOutput("drain_timeout", 1, 0);
    endtask

    task automatic waitWrites(input int n, input int budget);
        int k = 0;
        while (write_log.size() < n && k < budget) begin applyStimulus(1); k++; end
        if (k >= budget) checkOutput("write_timeout", write_log.size(), n);
    endtask

    task automatic doReset(input int cycles);
        rst_n = 0; req_val = '0;
        for (int r = 0; r < N; r++) jobs_left[r] = 0;
        applyStimulus(cycles);
        rst_n = 1;
        write_log.delete(); rsp_log.delete(); grant_log.delete(); grant_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int k;
        longint rise_cyc;
        for (int r = 0; r < N; r++) begin cur_key[r] = '0; cur_plain[r] = '0; jobs_left[r] = 0; end

        doReset(3);
        applyStimulus(2);
        checkOutput("idle_after_reset", {req_rdy, rsp_val, config_hsk, buffer_pop}, '0);

        $display("[TB] single job");
        loadJobs(0, 1, KEY1, PT1);
        waitDrain(60);
        checkOutput("t1_write_count", write_log.size(), 4);
        checkOutput("t1_addr0", write_log[0].addr, 16'h0010);
        checkOutput("t1_addr1", write_log[1].addr, 16'h0020);
        checkOutput("t1_addr2", write_log[2].addr, 16'h0030);
        checkOutput("t1_addr3", write_log[3].addr, 16'h0040);
        checkOutput("t1_first_write_cycle", write_log[0].c, grant_cyc[0] + 1);
        checkOutput("t1_consecutive", write_log[3].c, write_log[0].c + 3);
        checkOutput("t1_key_hi", {write_log[0].hi, write_log[0].lo}, 64'h0001020304050607);
        checkOutput("t1_pt_lo", {write_log[3].hi, write_log[3].lo}, 64'h8899aabbccddeeff);
        checkOutput("t1_rsp_count", rsp_log.size(), 1);
        checkOutput("t1_rsp_id", rsp_log[0].id, 0);
        checkOutput("t1_ciphertext", rsp_log[0].data, CT1);

        $display("[TB] all requesters");
        doReset(2);
        for (int r = 0; r < N; r++) loadJobs(r, 2, KEY1 + 128'(r * 64), PT1 ^ 128'(r));
        waitDrain(200);
        checkOutput("t2_grant_count", grant_log.size(), 8);
        checkOutput("t2_rsp_count", rsp_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t2_grant_order", grant_log[i], order[i]);
            checkOutput("t2_rsp_route", rsp_log[i].id, order[i]);
        end
        checkOutput("t2_job_spacing", grant_cyc[1] - grant_cyc[0], 5);

        $display("[TB] aes_ready stall");
        write_log.delete();
        aes_ready = 0;
        loadJobs(2, 1, 128'hcafe, 128'hbeef);
        waitWrites(3, 20);
        applyStimulus(5);
        aes_ready = 1; rise_cyc = cyc;
        waitDrain(40);
        checkOutput("t3_write_count", write_log.size(), 4);
        checkOutput("t3_pt_lo_on_rise", write_log[3].c, rise_cyc);
        checkOutput("t3_stall_len", write_log[3].c - write_log[2].c, 6);

        $display("[TB] fifo full");
        doReset(2);
        rsp_rdy = '0;
        for (int r = 0; r < N; r++) loadJobs(r, 5, 128'h1000 * 128'(r + 1), 128'h77 * 128'(r + 1));
        k = 0;
        while (m_ids.size() < DEPTH && k < 200) begin applyStimulus(1); k++; end
        if (k >= 200) checkOutput("t4_fill_timeout", m_ids.size(), DEPTH);
        applyStimulus(20);
        checkOutput("t4_grants_when_full", grant_log.size(), 16);
        rsp_rdy = 4'b0001;
        applyStimulus(1);
        rsp_rdy = '0;
        checkOutput("t4_single_pop", rsp_log.size(), 1);
        applyStimulus(15);
        checkOutput("t4_one_new_grant", grant_log.size(), 17);
        rsp_rdy = '1;
        waitDrain(300);
        checkOutput("t4_total_rsp", rsp_log.size(), 20);

        $display("[TB] reset mid-job");
        doReset(2);
        rsp_rdy = '0;
        loadJobs(3, 2, 128'h3333, 128'h4444);
        k = 0;
        while (m_ids.size() < 2 && k < 40) begin applyStimulus(1); k++; end
        loadJobs(1, 1, 128'h5555, 128'h6666);
        waitWrites(9, 20);
        doReset(1);
        rsp_rdy = '1;
        applyStimulus(5);
        checkOutput("t5_quiet_after_reset", write_log.size() + rsp_log.size(), 0);
        loadJobs(2, 1, 128'h7777, 128'h8888);
        loadJobs(0, 1, 128'h9999, 128'haaaa);
        waitDrain(60);
        checkOutput("t5_first_grant", grant_log[0], 0);
        checkOutput("t5_second_grant", grant_log[1], 2);
        checkOutput("t5_rsp_count", rsp_log.size(), 2);
        checkOutput("t5_rsp_first", rsp_log[0].id, 0);

`ifdef AES_SCHED_KEY_CACHE_EN
        $display("[TB] key cache");
        doReset(2);
        fixed_key = 1;
        loadJobs(1, 2, KEY1, PT1);
        waitDrain(60);
        checkOutput("t6_cached_writes", write_log.size(), 6);
        checkOutput("t6_second_first_addr", write_log[4].addr, 16'h0030);
        fixed_key = 0;
        loadJobs(1, 1, KEY1 ^ 128'h1, PT1);
        waitDrain(60);
        checkOutput("t6_new_key_writes", write_log.size(), 10);
        checkOutput("t6_new_key_addr", write_log[6].addr, 16'h0010);
`endif

        applyStimulus(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
